// File: rtl/wpath_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// wpath_mem_arb_pkg
// Shared definitions for the write-path memory arbiter:
//   - system sizing (core count, bank count, largest data value)
//   - the transaction record carried on every core/bank link
//   - core index and per-core pending-count types
//   - small helpers for protocol-error detection and round-robin pointer advance
// -----------------------------------------------------------------------------
package wpath_mem_arb_pkg;

    localparam int NCORES   = 2;
    localparam int NMEMS    = 2;
    localparam int DATA_MAX = 3;

    localparam int DATA_W = $clog2(DATA_MAX + 1);
    // One bit wider than needed for NMEMS so that an illegal bank number can be
    // represented on the link and flagged as a protocol error.
    localparam int ADDR_W = $clog2(NMEMS) + 1;
    localparam int CORE_W = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int PEND_W = $clog2(NMEMS + 1);

    typedef enum logic {
        TX_WR = 1'b0,
        TX_RD = 1'b1
    } tx_kind_t;

    typedef struct packed {
        tx_kind_t            kind;
        logic [ADDR_W-1:0]   mem_addr;
        logic [DATA_W-1:0]   data;
        logic                acq_rel;
    } tx_t;

    typedef logic [CORE_W-1:0] core_id_t;
    typedef logic [PEND_W-1:0] pend_cnt_t;

    // A transaction the write path cannot route: wrong kind or no such bank.
    function automatic logic txIsBad(input tx_t tx);
        return (tx.kind != TX_WR) || (tx.mem_addr >= ADDR_W'(NMEMS));
    endfunction

    // Round-robin successor of a core index, wrapping at NCORES.
    function automatic core_id_t nextCore(input core_id_t id);
        return (int'(id) == NCORES - 1) ? '0 : core_id_t'(id + 1'b1);
    endfunction

endpackage

// File: rtl/wpath_mem_arb_rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// Purely combinational round-robin picker. Grants the first requester found
// at or after the pointer position, wrapping around modulo N.
// Ports:
//   req_i      N-bit request vector
//   ptr_i      index of the highest-priority requester this cycle
//   gnt_o      one-hot grant (all zero when nobody requests)
//   gnt_idx_o  binary index of the granted requester
//   any_o      a grant was issued
// -----------------------------------------------------------------------------
module rr_arb #(
    parameter int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] gnt_idx_o,
    output logic         any_o
);

    // Walk the requesters starting at the pointer; the first hit wins and
    // blocks every later candidate.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[idx]) begin
                any_o       = 1'b1;
                gnt_o[idx]  = 1'b1;
                gnt_idx_o   = W'(idx);
            end
        end
    end

endmodule

// File: rtl/wpath_mem_arb.sv
// -----------------------------------------------------------------------------
// wpath_mem_arb
// Write-path arbiter between the cores and the memory banks. Each core link
// carries write transactions that are routed by mem_addr into a single-entry
// output buffer per bank. Cores contending for one bank are served
// round-robin. A release write (acq_rel=1) waits until every earlier write
// from the same core has left its output buffer.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cores2wpath_src_rdy_i     per-core "transaction offered"
//   cores2wpath_tx_i          per-core offered transaction
//   cores2wpath_tgt_rdy_o     per-core "transaction taken this cycle"
//   wpath2mems_src_rdy_o      per-bank "buffered transaction offered"
//   wpath2mems_tx_o           per-bank buffered transaction
//   wpath2mems_tgt_rdy_i      per-bank "bank takes it this cycle"
//   err_proto_o               sticky: an unroutable transaction was accepted
//   busy_o                    any buffer full or any write still in flight
// -----------------------------------------------------------------------------
module wpath_mem_arb
    import wpath_mem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NCORES-1:0]   cores2wpath_src_rdy_i,
    input  tx_t  [NCORES-1:0]   cores2wpath_tx_i,
    output logic [NCORES-1:0]   cores2wpath_tgt_rdy_o,
    output logic [NMEMS-1:0]    wpath2mems_src_rdy_o,
    output tx_t  [NMEMS-1:0]    wpath2mems_tx_o,
    input  logic [NMEMS-1:0]    wpath2mems_tgt_rdy_i,
    output logic                err_proto_o,
    output logic                busy_o
);

    logic      [NMEMS-1:0]  valid_q, valid_d;
    tx_t       [NMEMS-1:0]  tx_q, tx_d;
    core_id_t  [NMEMS-1:0]  owner_q, owner_d;
    core_id_t  [NMEMS-1:0]  rrPtr_q, rrPtr_d;
    pend_cnt_t [NCORES-1:0] pend_q, pend_d;
    logic                   errProto_q, errProto_d;

    logic [NCORES-1:0] isBad;
    logic [NCORES-1:0] relBlocked;
    logic [NCORES-1:0] granted;
    logic [NCORES-1:0] errAcc;
    logic [NMEMS-1:0]  drain;
    logic [NMEMS-1:0]  bankAny;
    logic [NCORES-1:0] bankReq [NMEMS];
    logic [NCORES-1:0] bankGnt [NMEMS];
    core_id_t          gntIdx  [NMEMS];
    int                pendWide [NCORES];
    logic              pendAny;

    // Build each bank's request vector. A core may bid only for the bank it
    // addresses, only with a routable transaction, only if it is not a
    // release still waiting on older writes, and only if the bank buffer is
    // free now or is being emptied this very cycle (back-to-back streaming).
    always_comb begin
        isBad      = '0;
        relBlocked = '0;
        drain      = '0;
        for (int m = 0; m < NMEMS; m++) begin
            bankReq[m] = '0;
        end
        for (int c = 0; c < NCORES; c++) begin
            isBad[c]      = txIsBad(cores2wpath_tx_i[c]);
            relBlocked[c] = cores2wpath_tx_i[c].acq_rel && (pend_q[c] != '0);
        end
        for (int m = 0; m < NMEMS; m++) begin
            drain[m] = valid_q[m] && wpath2mems_tgt_rdy_i[m];
            for (int c = 0; c < NCORES; c++) begin
                bankReq[m][c] = cores2wpath_src_rdy_i[c] && !isBad[c] && !relBlocked[c]
                              && (cores2wpath_tx_i[c].mem_addr == ADDR_W'(m))
                              && (!valid_q[m] || drain[m]);
            end
        end
    end

    // One round-robin picker per bank; the pointer registers live here.
    for (genvar m = 0; m < NMEMS; m++) begin : g_bank
        rr_arb #(.N(NCORES)) u_rr (
            .req_i     (bankReq[m]),
            .ptr_i     (rrPtr_q[m]),
            .gnt_o     (bankGnt[m]),
            .gnt_idx_o (gntIdx[m]),
            .any_o     (bankAny[m])
        );
    end

    // Merge bank grants into per-core ready. Unroutable transactions are
    // swallowed only in a cycle where no bank grant is issued, so they never
    // steal throughput from real writes. Ready is forced low during reset.
    always_comb begin
        granted = '0;
        errAcc  = '0;
        for (int m = 0; m < NMEMS; m++) begin
            granted = granted | bankGnt[m];
        end
        for (int c = 0; c < NCORES; c++) begin
            errAcc[c] = cores2wpath_src_rdy_i[c] && isBad[c] && !relBlocked[c] && !(|bankAny);
        end
        cores2wpath_tgt_rdy_o = rst ? '0 : (granted | errAcc);
    end

    // Next-state: load a buffer on grant (load wins over drain, which is how
    // a full buffer is refilled in its drain cycle), advance the bank pointer
    // past the grantee, and track each core's writes still sitting in a
    // buffer. A core can own several buffers, so several may drain at once.
    always_comb begin
        int pendNext;
        pendNext   = 0;
        valid_d    = valid_q;
        tx_d       = tx_q;
        owner_d    = owner_q;
        rrPtr_d    = rrPtr_q;
        pend_d     = pend_q;
        errProto_d = errProto_q | (|errAcc);
        for (int c = 0; c < NCORES; c++) begin
            pendWide[c] = 0;
        end
        for (int m = 0; m < NMEMS; m++) begin
            if (bankAny[m]) begin
                valid_d[m] = 1'b1;
                tx_d[m]    = cores2wpath_tx_i[gntIdx[m]];
                owner_d[m] = gntIdx[m];
                rrPtr_d[m] = nextCore(gntIdx[m]);
            end else if (drain[m]) begin
                valid_d[m] = 1'b0;
            end
        end
        for (int c = 0; c < NCORES; c++) begin
            pendNext = int'(pend_q[c]) + (granted[c] ? 1 : 0);
            for (int m = 0; m < NMEMS; m++) begin
                if (drain[m] && (owner_q[m] == core_id_t'(c))) begin
                    pendNext = pendNext - 1;
                end
            end
            pendWide[c] = pendNext;
            pend_d[c]   = pend_cnt_t'(pendNext);
        end
    end

    // State registers; reset discards any buffered writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            tx_q       <= '0;
            owner_q    <= '0;
            rrPtr_q    <= '0;
            pend_q     <= '0;
            errProto_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            tx_q       <= tx_d;
            owner_q    <= owner_d;
            rrPtr_q    <= rrPtr_d;
            pend_q     <= pend_d;
            errProto_q <= errProto_d;
        end
    end

    // Status outputs come straight from registers.
    always_comb begin
        pendAny = 1'b0;
        for (int c = 0; c < NCORES; c++) begin
            pendAny = pendAny | (pend_q[c] != '0);
        end
    end

    assign wpath2mems_src_rdy_o = valid_q;
    assign wpath2mems_tx_o      = tx_q;
    assign err_proto_o          = errProto_q;
    assign busy_o               = (|valid_q) || pendAny;

    for (genvar m = 0; m < NMEMS; m++) begin : g_bank_chk
        a_out_stable: assert property (@(posedge clk) disable iff (rst)
            (valid_q[m] && !wpath2mems_tgt_rdy_i[m]) |=> (valid_q[m] && $stable(tx_q[m])));
        a_one_gnt: assert property (@(posedge clk) disable iff (rst)
            $onehot0(bankGnt[m]));
    end

    for (genvar c = 0; c < NCORES; c++) begin : g_core_chk
        a_rel_order: assert property (@(posedge clk) disable iff (rst)
            (cores2wpath_src_rdy_i[c] && cores2wpath_tgt_rdy_o[c] && cores2wpath_tx_i[c].acq_rel)
            |-> (pend_q[c] == '0));
        a_pend_range: assert property (@(posedge clk) disable iff (rst)
            (pendWide[c] >= 0) && (pendWide[c] <= NMEMS));
    end

endmodule

// File: tb/tb_wpath_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_wpath_mem_arb
// Directed bench for the write-path arbiter. Test code pushes the expected
// bank-side transactions into a scoreboard in hand-worked order; a monitor
// pops and compares whenever a bank link transfers. Timing and status are
// checked directly by the test sequence.
// -----------------------------------------------------------------------------
module tb_wpath_mem_arb;
    import wpath_mem_arb_pkg::*;

    typedef struct {
        int  bank;
        tx_t tx;
    } exp_t;

    logic               clk;
    logic               rst;
    logic [NCORES-1:0]  coreSrcRdy;
    tx_t  [NCORES-1:0]  coreTx;
    logic [NCORES-1:0]  coreTgtRdy;
    logic [NMEMS-1:0]   memSrcRdy;
    tx_t  [NMEMS-1:0]   memTx;
    logic [NMEMS-1:0]   memTgtRdy;
    logic               errProto;
    logic               busy;

    int   cycle = 0;
    int   nCompared = 0;
    int   nMismatched = 0;
    exp_t expQ[$];

    wpath_mem_arb dut (
        .clk                   (clk),
        .rst                   (rst),
        .cores2wpath_src_rdy_i (coreSrcRdy),
        .cores2wpath_tx_i      (coreTx),
        .cores2wpath_tgt_rdy_o (coreTgtRdy),
        .wpath2mems_src_rdy_o  (memSrcRdy),
        .wpath2mems_tx_o       (memTx),
        .wpath2mems_tgt_rdy_i  (memTgtRdy),
        .err_proto_o           (errProto),
        .busy_o                (busy)
    );

    // 10-unit clock and a free-running cycle index used to time acceptances.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle++;

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic tx_t mkTx(input tx_kind_t k, input int addr, input int data, input logic acq);
        tx_t t;
        t.kind     = k;
        t.mem_addr = ADDR_W'(addr);
        t.data     = DATA_W'(data);
        t.acq_rel  = acq;
        return t;
    endfunction

    task automatic pushExp(input int bank, input tx_t t);
        exp_t e;
        e.bank = bank;
        e.tx   = t;
        expQ.push_back(e);
    endtask

    // Offer one transaction on a core link and hold it until taken (bounded).
    // Returns the cycle in which the handshake happened; returns at the
    // following posedge + 1 with src_rdy dropped.
    task automatic applyStimulus(input int c, input tx_t t, output int accCyc);
        int budget;
        budget = 60;
        accCyc = -1;
        coreTx[c]     = t;
        coreSrcRdy[c] = 1'b1;
        while (budget > 0 && accCyc < 0) begin
            @(negedge clk);
            if (coreTgtRdy[c]) accCyc = cycle;
            budget--;
        end
        @(posedge clk);
        #1;
        coreSrcRdy[c] = 1'b0;
        if (accCyc < 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL accept timeout core %0d: got no tgt_rdy, expected one within 60 cycles", c);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every bank-side transfer must match the oldest expectation
    // queued for that bank.
    always @(negedge clk) begin
        int found;
        if (!rst) begin
            for (int m = 0; m < NMEMS; m++) begin
                if (memSrcRdy[m] && memTgtRdy[m]) begin
                    found = -1;
                    foreach (expQ[i]) begin
                        if (found < 0 && expQ[i].bank == m) found = i;
                    end
                    if (found < 0) begin
                        nCompared++;
                        nMismatched++;
                        $display("[TB] FAIL bank %0d unexpected tx: got %0h, expected none", m, memTx[m]);
                    end else begin
                        checkOutput($sformatf("bank %0d tx", m), 32'(memTx[m]), 32'(expQ[found].tx));
                        expQ.delete(found);
                    end
                end
            end
        end
    end

    initial begin
        int acc0;
        int acc1;
        int accA;
        int accB;
        int issue;
        int accs0 [3];
        int accs1 [3];

        rst        = 1'b0;
        coreSrcRdy = '0;
        coreTx     = '0;
        memTgtRdy  = '1;

        // Reset: offer a routable write so that ready really has to be gated.
        #2 rst = 1'b1;
        coreTx[0]     = mkTx(TX_WR, 0, 0, 1'b0);
        coreSrcRdy[0] = 1'b1;
        @(negedge clk);
        checkOutput("reset tgt_rdy", 32'(coreTgtRdy), 0);
        checkOutput("reset src_rdy", 32'(memSrcRdy), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset err_proto", 32'(errProto), 0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        coreSrcRdy = '0;
        idle(2);

        // T1: single write core 0 -> bank 1, latency one, busy for one cycle.
        pushExp(1, mkTx(TX_WR, 1, 2, 1'b0));
        applyStimulus(0, mkTx(TX_WR, 1, 2, 1'b0), acc0);
        @(negedge clk);
        checkOutput("T1 latency", cycle, acc0 + 1);
        checkOutput("T1 src_rdy", 32'(memSrcRdy), 32'b10);
        checkOutput("T1 busy during", 32'(busy), 1);
        @(negedge clk);
        checkOutput("T1 src_rdy after", 32'(memSrcRdy), 0);
        checkOutput("T1 busy after", 32'(busy), 0);
        idle(2);

        // T2: both cores stream into bank 0; grants alternate 0,1,0,1,...
        pushExp(0, mkTx(TX_WR, 0, 0, 1'b0));
        pushExp(0, mkTx(TX_WR, 0, 3, 1'b0));
        pushExp(0, mkTx(TX_WR, 0, 1, 1'b0));
        pushExp(0, mkTx(TX_WR, 0, 2, 1'b0));
        pushExp(0, mkTx(TX_WR, 0, 2, 1'b0));
        pushExp(0, mkTx(TX_WR, 0, 1, 1'b0));
        fork
            begin
                for (int i = 0; i < 3; i++) applyStimulus(0, mkTx(TX_WR, 0, i, 1'b0), accs0[i]);
            end
            begin
                for (int i = 0; i < 3; i++) applyStimulus(1, mkTx(TX_WR, 0, 3 - i, 1'b0), accs1[i]);
            end
        join
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("T2 core1 follows core0 #%0d", i), accs1[i], accs0[i] + 1);
        end
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("T2 core0 spacing #%0d", i), accs0[i + 1], accs0[i] + 2);
        end
        idle(3);

        // T3: release write stalls behind an undrained write to bank 0.
        memTgtRdy[0] = 1'b0;
        pushExp(0, mkTx(TX_WR, 0, 1, 1'b0));
        pushExp(1, mkTx(TX_WR, 1, 3, 1'b1));
        applyStimulus(0, mkTx(TX_WR, 0, 1, 1'b0), accA);
        fork
            applyStimulus(0, mkTx(TX_WR, 1, 3, 1'b1), accB);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    checkOutput($sformatf("T3 release stalled %0d", i), 32'(coreTgtRdy[0]), 0);
                end
                @(posedge clk);
                #1;
                memTgtRdy[0] = 1'b1;
            end
        join
        checkOutput("T3 release accept cycle", accB, accA + 7);
        @(negedge clk);
        checkOutput("T3 release on bank 1", 32'(memSrcRdy), 32'b10);
        idle(3);

        // T4: disjoint banks are served in parallel.
        pushExp(0, mkTx(TX_WR, 0, 2, 1'b0));
        pushExp(1, mkTx(TX_WR, 1, 1, 1'b0));
        fork
            applyStimulus(0, mkTx(TX_WR, 0, 2, 1'b0), acc0);
            applyStimulus(1, mkTx(TX_WR, 1, 1, 1'b0), acc1);
        join
        checkOutput("T4 parallel accept", acc1, acc0);
        @(negedge clk);
        checkOutput("T4 both banks valid", 32'(memSrcRdy), 32'b11);
        idle(3);

        // T5: a read on the write path is swallowed and flagged.
        checkOutput("T5 err before", 32'(errProto), 0);
        applyStimulus(1, mkTx(TX_RD, 0, 1, 1'b0), acc1);
        @(negedge clk);
        checkOutput("T5 err set", 32'(errProto), 1);
        checkOutput("T5 no output", 32'(memSrcRdy), 0);
        checkOutput("T5 not busy", 32'(busy), 0);
        idle(3);
        checkOutput("T5 err sticky", 32'(errProto), 1);

        // T6: reset with both buffers full and one write pending per core.
        memTgtRdy = '0;
        fork
            applyStimulus(0, mkTx(TX_WR, 0, 3, 1'b0), acc0);
            applyStimulus(1, mkTx(TX_WR, 1, 2, 1'b0), acc1);
        join
        @(negedge clk);
        checkOutput("T6 both full", 32'(memSrcRdy), 32'b11);
        checkOutput("T6 busy", 32'(busy), 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("T6 src_rdy in reset", 32'(memSrcRdy), 0);
        checkOutput("T6 tgt_rdy in reset", 32'(coreTgtRdy), 0);
        checkOutput("T6 busy in reset", 32'(busy), 0);
        checkOutput("T6 err cleared", 32'(errProto), 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        memTgtRdy = '1;
        idle(1);

        // After reset: pending is zero, so a release goes straight through.
        pushExp(1, mkTx(TX_WR, 1, 0, 1'b1));
        issue = cycle;
        applyStimulus(0, mkTx(TX_WR, 1, 0, 1'b1), acc0);
        checkOutput("T6 release immediate", acc0, issue);
        idle(2);

        // After reset: bank 0 pointer is back at core 0.
        pushExp(0, mkTx(TX_WR, 0, 1, 1'b0));
        pushExp(0, mkTx(TX_WR, 0, 2, 1'b0));
        fork
            applyStimulus(0, mkTx(TX_WR, 0, 1, 1'b0), acc0);
            applyStimulus(1, mkTx(TX_WR, 0, 2, 1'b0), acc1);
        join
        checkOutput("T6 rr_ptr reset core1 second", acc1, acc0 + 1);
        idle(3);

        // T7: bank number out of range is also a protocol error.
        checkOutput("T7 err before", 32'(errProto), 0);
        applyStimulus(0, mkTx(TX_WR, 2, 0, 1'b0), acc0);
        @(negedge clk);
        checkOutput("T7 err set", 32'(errProto), 1);
        checkOutput("T7 no output", 32'(memSrcRdy), 0);
        idle(3);

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
